// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional same-cycle response bypass is enabled by defining IFU_BYPASS_EN.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Synchronous FIFO of fetched {pc, instruction} entries with flush and occupancy count.
// Pointers wrap naturally because the depth is a power of two.
module instruction_fetch_queue
  import instruction_fetch_pkg::*;
#(
  parameter int  QDEPTH = 2,
  localparam int CW     = $clog2(QDEPTH + 1),
  localparam int PW     = $clog2(QDEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  fetch_entry_t  r_mem [QDEPTH];

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CW'(QDEPTH));
  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_do_push && w_full && !w_do_pop));

endmodule

// File: rtl/instruction_fetch.sv
// Front-end fetch unit: sequential word fetch, in-order response buffering and redirect flush.
// Define IFU_BYPASS_EN to forward a kept response to decode in the same cycle when the buffer is empty.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int          QDEPTH   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_resp_valid,
  input  logic [31:0]  imem_resp_data,
  output logic         id_valid,
  input  logic         id_ready,
  output logic [31:0]  id_instruction,
  output logic [31:0]  id_pc,
  output fetch_state_e dbg_state
);

  localparam int CW = $clog2(QDEPTH + 1);

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
    $error("instruction_fetch: QDEPTH must be a power of two and at least 2");
  end

  fetch_state_e  r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop_cnt;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_resp_entry;
  fetch_entry_t  w_id_entry;
  logic [CW:0]   w_occupancy;
  logic [CW-1:0] w_inflight_after_resp;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_dropping;
  logic          w_keep;
  logic          w_buf_empty;
  logic          w_bypass;
  logic          w_id_valid;
  logic          w_pop;
  logic          w_push;

  // Requests are capped so that every accepted request has a guaranteed buffer slot.
  assign w_occupancy = {1'b0, r_inflight} + {1'b0, w_count};
  assign w_req_valid = (r_state != BOOT) && !redirect_valid
                       && (w_occupancy < (CW + 1)'(QDEPTH));
  assign w_req_fire  = w_req_valid && imem_req_ready;

  assign w_inflight_after_resp = imem_resp_valid ? (r_inflight - 1'b1) : r_inflight;

  assign w_dropping   = (r_drop_cnt != '0);
  assign w_keep       = imem_resp_valid && !w_dropping && !redirect_valid;
  assign w_buf_empty  = (w_count == '0);
  assign w_resp_entry = '{pc: r_resp_pc, inst: imem_resp_data};

`ifdef IFU_BYPASS_EN
  assign w_bypass = w_keep && w_buf_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_id_valid = (!w_buf_empty || w_bypass) && !redirect_valid;
  assign w_pop      = !w_buf_empty && w_id_valid && id_ready;
  assign w_push     = w_keep && !(w_bypass && id_ready);

  // With nothing to present, show a NOP at the PC the next kept response will carry.
  always_comb begin
    w_id_entry = '{pc: r_resp_pc, inst: NOP};
    if (!w_buf_empty) begin
      w_id_entry = w_head;
    end else if (w_bypass) begin
      w_id_entry = w_resp_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      r_fetch_pc <= word_align(redirect_pc);
      r_resp_pc  <= word_align(redirect_pc);
      r_inflight <= w_inflight_after_resp;
      r_drop_cnt <= w_inflight_after_resp;
      r_state    <= (w_inflight_after_resp != '0) ? DRAIN : RUN;
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_keep) begin
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      r_inflight <= w_inflight_after_resp + CW'(w_req_fire);
      if (imem_resp_valid && w_dropping) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end
      case (r_state)
        BOOT:    r_state <= RUN;
        RUN:     r_state <= RUN;
        DRAIN: begin
          if (imem_resp_valid && (r_drop_cnt == CW'(1))) begin
            r_state <= RUN;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  instruction_fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_resp_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign id_valid       = w_id_valid;
  assign id_instruction = w_id_entry.inst;
  assign id_pc          = w_id_entry.pc;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// scored against the expected decode stream (accepted request addresses since the last redirect).
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0200;
  localparam int          QDEPTH   = 2;

  logic         clk;
  logic         rst_n;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_resp_valid;
  logic [31:0]  imem_resp_data;
  logic         id_valid;
  logic         id_ready;
  logic [31:0]  id_instruction;
  logic [31:0]  id_pc;
  fetch_state_e dbg_state;

  instruction_fetch #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instruction  (id_instruction),
    .id_pc           (id_pc),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_decoded = 0;

  int req_ready_pct = 100;
  int resp_pct      = 100;
  int id_ready_pct  = 100;
  int mem_mode      = 0;

  logic        do_redirect = 1'b0;
  logic [31:0] redirect_target = '0;

  logic [31:0] pend_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_req_addr = RESET_PC;

  logic         s_req_valid, s_req_fire, s_resp_valid, s_id_valid, s_id_fire;
  logic [31:0]  s_req_addr, s_id_pc, s_id_inst;
  fetch_state_e s_state;

  function automatic logic [31:0] mem_fn(input logic [31:0] addr);
    case (mem_mode)
      0:       return NOP;
      2:       return 32'hDEAD_BEEF;
      default: return {~addr[15:0], addr[15:0]};
    endcase
  endfunction

  task automatic drive_idle();
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    id_ready        = 1'b0;
  endtask

  task automatic clear_model();
    pend_q.delete();
    exp_q.delete();
    exp_req_addr = RESET_PC;
    do_redirect  = 1'b0;
  endtask

  // One clock: drive after the edge, sample and score at the falling edge.
  task automatic cycle();
    logic [63:0] exp;
    @(posedge clk);
    #1;
    imem_req_ready = (int'($urandom_range(0, 99)) < req_ready_pct);
    if (pend_q.size() > 0 && int'($urandom_range(0, 99)) < resp_pct) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_fn(pend_q[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    id_ready       = (int'($urandom_range(0, 99)) < id_ready_pct);
    redirect_valid = do_redirect;
    redirect_pc    = do_redirect ? redirect_target : $urandom;
    do_redirect    = 1'b0;
    @(negedge clk);
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_req_fire   = imem_req_valid && imem_req_ready;
    s_resp_valid = imem_resp_valid;
    s_id_valid   = id_valid;
    s_id_fire    = id_valid && id_ready;
    s_id_pc      = id_pc;
    s_id_inst    = id_instruction;
    s_state      = dbg_state;

    if (imem_req_valid) begin
      n_checks++;
      if (imem_req_addr !== exp_req_addr) begin
        n_fail++;
        $display("FAIL req_addr: got %h, expected %h", imem_req_addr, exp_req_addr);
      end
    end
    if (redirect_valid) begin
      n_checks++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL redirect_quiet: req_valid=%b id_valid=%b, expected 0 0",
                 imem_req_valid, id_valid);
      end
      exp_q.delete();
      exp_req_addr = {redirect_pc[31:2], 2'b00};
    end else if (s_id_fire) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL id_unexpected: got pc=%h inst=%h, expected no instruction",
                 id_pc, id_instruction);
      end else begin
        exp = exp_q.pop_front();
        n_decoded++;
        if ({id_pc, id_instruction} !== exp) begin
          n_fail++;
          $display("FAIL id_stream: got pc=%h inst=%h, expected pc=%h inst=%h",
                   id_pc, id_instruction, exp[63:32], exp[31:0]);
        end
      end
    end
    if (s_req_fire) begin
      exp_q.push_back({exp_req_addr, mem_fn(exp_req_addr)});
      pend_q.push_back(exp_req_addr);
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (imem_resp_valid) begin
      void'(pend_q.pop_front());
    end
    n_checks++;
    if (pend_q.size() > QDEPTH) begin
      n_fail++;
      $display("FAIL inflight_cap: got %0d outstanding, expected <= %0d", pend_q.size(), QDEPTH);
    end
  endtask

  // Reset, release away from the edge, and return at the falling edge of the BOOT cycle.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    clear_model();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_req_valid: got %b, expected 0", imem_req_valid);
    end
    n_checks++;
    if (imem_req_addr !== RESET_PC) begin
      n_fail++; $display("FAIL rst_req_addr: got %h, expected %h", imem_req_addr, RESET_PC);
    end
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_id_valid: got %b, expected 0", id_valid);
    end
    n_checks++;
    if (id_instruction !== 32'h0000_0013) begin
      n_fail++; $display("FAIL rst_id_inst: got %h, expected 00000013", id_instruction);
    end
    n_checks++;
    if (id_pc !== RESET_PC) begin
      n_fail++; $display("FAIL rst_id_pc: got %h, expected %h", id_pc, RESET_PC);
    end
    n_checks++;
    if (dbg_state !== BOOT) begin
      n_fail++; $display("FAIL rst_state: got %0d, expected BOOT", dbg_state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0 || dbg_state !== BOOT) begin
      n_fail++;
      $display("FAIL boot_cycle: got req_valid=%b state=%0d, expected 0 BOOT", imem_req_valid, dbg_state);
    end
    mem_mode = 0; req_ready_pct = 100; resp_pct = 100; id_ready_pct = 100;
    cycle();
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: got valid=%b addr=%h, expected 1 %h", s_req_valid, s_req_addr, RESET_PC);
    end
  endtask

  task automatic test_basic_stream();
    logic [31:0] reqs[$];
    logic        got_id;
    logic [31:0] first_pc, first_inst;
    got_id = 1'b0;
    first_pc = '0;
    first_inst = '0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_req_fire) reqs.push_back(s_req_addr);
      if (s_id_fire && !got_id) begin
        got_id = 1'b1; first_pc = s_id_pc; first_inst = s_id_inst;
      end
    end
    n_checks++;
    if (!got_id || first_pc !== RESET_PC || first_inst !== NOP) begin
      n_fail++;
      $display("FAIL basic_first_id: got seen=%b pc=%h inst=%h, expected 1 %h 00000013",
               got_id, first_pc, first_inst, RESET_PC);
    end
    n_checks++;
    if (reqs.size() < 2 || reqs[0] !== 32'h204 || reqs[1] !== 32'h208) begin
      n_fail++;
      $display("FAIL basic_req_seq: got %0d reqs first=%h, expected 00000204 then 00000208",
               reqs.size(), (reqs.size() > 0) ? reqs[0] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    logic [31:0] pcs[$];
    logic [31:0] resume_addr;
    logic        resumed;
    apply_reset();
    mem_mode = 1; req_ready_pct = 100; resp_pct = 100; id_ready_pct = 0;
    nreq = 0;
    repeat (10) begin
      cycle();
      if (s_req_fire) nreq++;
    end
    n_checks++;
    if (nreq != QDEPTH || s_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall: got %0d reqs, req_valid=%b, expected %0d reqs, 0", nreq, s_req_valid, QDEPTH);
    end
    n_checks++;
    if (s_id_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_id_valid: got %b, expected 1", s_id_valid);
    end
    id_ready_pct = 100;
    resumed = 1'b0;
    resume_addr = '0;
    for (int i = 0; i < 10 && (pcs.size() < 2 || !resumed); i++) begin
      cycle();
      if (s_id_fire) pcs.push_back(s_id_pc);
      if (s_req_fire && !resumed) begin
        resumed = 1'b1; resume_addr = s_req_addr;
      end
    end
    n_checks++;
    if (pcs.size() < 2 || pcs[0] !== 32'h200 || pcs[1] !== 32'h204) begin
      n_fail++;
      $display("FAIL bp_order: got %0d items first=%h, expected 00000200 then 00000204",
               pcs.size(), (pcs.size() > 0) ? pcs[0] : 32'hx);
    end
    n_checks++;
    if (!resumed || resume_addr !== 32'h208) begin
      n_fail++; $display("FAIL bp_resume: got seen=%b addr=%h, expected 1 00000208", resumed, resume_addr);
    end
  endtask

  task automatic test_redirect_inflight();
    logic got_id;
    apply_reset();
    mem_mode = 1; req_ready_pct = 100; resp_pct = 0; id_ready_pct = 100;
    repeat (5) cycle();
    n_checks++;
    if (s_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rdi_capped: got req_valid=%b, expected 0", s_req_valid);
    end
    do_redirect = 1'b1;
    redirect_target = 32'h0000_1000;
    cycle();
    resp_pct = 100;
    cycle();
    n_checks++;
    if (s_state !== DRAIN) begin
      n_fail++; $display("FAIL rdi_state: got %0d, expected DRAIN", s_state);
    end
    got_id = s_id_fire;
    for (int i = 0; i < 30 && !got_id; i++) begin
      cycle();
      got_id = s_id_fire;
    end
    n_checks++;
    if (!got_id || s_id_pc !== 32'h1000 || s_id_inst !== mem_fn(32'h1000)) begin
      n_fail++;
      $display("FAIL rdi_first_id: got seen=%b pc=%h inst=%h, expected 1 00001000 %h",
               got_id, s_id_pc, s_id_inst, mem_fn(32'h1000));
    end
  endtask

  task automatic test_redirect_with_resp();
    logic got_id;
    apply_reset();
    mem_mode = 1; req_ready_pct = 100; resp_pct = 0; id_ready_pct = 100;
    repeat (5) cycle();
    resp_pct = 100;
    do_redirect = 1'b1;
    redirect_target = 32'h0000_2002;
    cycle();
    cycle();
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h2000) begin
      n_fail++;
      $display("FAIL rdr_next_req: got valid=%b addr=%h, expected 1 00002000", s_req_valid, s_req_addr);
    end
    n_checks++;
    if (s_state !== DRAIN || s_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdr_drain: got state=%0d id_valid=%b, expected DRAIN 0", s_state, s_id_valid);
    end
    cycle();
    n_checks++;
    if (s_state !== RUN) begin
      n_fail++; $display("FAIL rdr_run: got %0d, expected RUN", s_state);
    end
    got_id = s_id_fire;
    for (int i = 0; i < 30 && !got_id; i++) begin
      cycle();
      got_id = s_id_fire;
    end
    n_checks++;
    if (!got_id || s_id_pc !== 32'h2000) begin
      n_fail++; $display("FAIL rdr_first_id: got seen=%b pc=%h, expected 1 00002000", got_id, s_id_pc);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    mem_mode = 1; req_ready_pct = 100; resp_pct = 100; id_ready_pct = 0;
    repeat (8) cycle();
    n_checks++;
    if (s_id_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_full: got id_valid=%b, expected 1", s_id_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: got id_valid=%b req_valid=%b, expected 0 0", id_valid, imem_req_valid);
    end
    n_checks++;
    if (imem_req_addr !== RESET_PC || dbg_state !== BOOT) begin
      n_fail++;
      $display("FAIL mid_regs: got addr=%h state=%0d, expected %h BOOT", imem_req_addr, dbg_state, RESET_PC);
    end
    drive_idle();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    id_ready_pct = 100;
    cycle();
    n_checks++;
    if (s_req_fire !== 1'b1 || s_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL mid_restart: got fire=%b addr=%h, expected 1 %h", s_req_fire, s_req_addr, RESET_PC);
    end
  endtask

  task automatic test_bypass_latency();
    apply_reset();
    mem_mode = 2; req_ready_pct = 100; resp_pct = 0; id_ready_pct = 100;
    cycle();
    resp_pct = 100;
    cycle();
`ifdef IFU_BYPASS_EN
    n_checks++;
    if (s_id_valid !== 1'b1 || s_id_inst !== 32'hDEAD_BEEF || s_id_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: got valid=%b inst=%h pc=%h, expected 1 deadbeef 00000200",
               s_id_valid, s_id_inst, s_id_pc);
    end
    resp_pct = 0;
    cycle();
    n_checks++;
    if (s_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_not_enqueued: got id_valid=%b, expected 0", s_id_valid);
    end
`else
    n_checks++;
    if (s_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_same_cycle: got id_valid=%b, expected 0", s_id_valid);
    end
    resp_pct = 0;
    cycle();
    n_checks++;
    if (s_id_valid !== 1'b1 || s_id_inst !== 32'hDEAD_BEEF || s_id_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL latency_next_cycle: got valid=%b inst=%h pc=%h, expected 1 deadbeef 00000200",
               s_id_valid, s_id_inst, s_id_pc);
    end
`endif
  endtask

  task automatic test_random();
    int start_decoded;
    apply_reset();
    mem_mode = 1;
    start_decoded = n_decoded;
    for (int phase = 0; phase < 20; phase++) begin
      req_ready_pct = int'($urandom_range(30, 100));
      resp_pct      = int'($urandom_range(20, 100));
      id_ready_pct  = int'($urandom_range(10, 100));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 99) < 4) begin
          do_redirect = 1'b1;
          redirect_target = ($urandom_range(0, 3) == 0)
                            ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                            : $urandom;
        end
        cycle();
      end
    end
    n_checks++;
    if (n_decoded - start_decoded < 200) begin
      n_fail++;
      $display("FAIL random_progress: got %0d decoded, expected at least 200", n_decoded - start_decoded);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_with_resp();
    test_reset_midstream();
    test_bypass_latency();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
